// File: rtl/bcd_7seg_scan_driver_if.sv
// Display-side bundle for the BCD scan driver:
// load/data/blank in, segment and digit pins out.
interface bcd_7seg_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);
  localparam int IDX_W =
    (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic                    load;
  logic [4*NUM_DIGITS-1:0] bcd_in;
  logic                    blank;
  logic [6:0]              seg;
  logic [NUM_DIGITS-1:0]   dig_en;
  logic [IDX_W-1:0]        digit_idx;
  logic                    error;

  modport master (
    output load, bcd_in, blank,
    input  seg, dig_en, digit_idx, error
  );

  modport slave (
    input  load, bcd_in, blank,
    output seg, dig_en, digit_idx, error
  );
endinterface

// File: rtl/bcd_7seg_scan_driver.sv
// Multiplexed BCD to 7-segment scan driver with
// leading-zero blanking, dash glyph and error flag.
module bcd_7seg_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int SCAN_DIV    = 1000,
  parameter int ACTIVE_LOW  = 0,
  parameter int LZ_SUPPRESS = 1
) (
  input logic clk,
  input logic rst,
  bcd_7seg_scan_driver_if.slave bus
);
  localparam int IDX_W =
    (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PS_W =
    (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = 4 * NUM_DIGITS;

  localparam logic [PS_W-1:0] PS_LAST =
    PS_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST =
    IDX_W'(NUM_DIGITS - 1);
  localparam logic [6:0] POL7 =
    (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] POLD =
    (ACTIVE_LOW != 0) ? '1 : '0;

  logic [BW-1:0]         r_shadow;
  logic [PS_W-1:0]       r_ps;
  logic [IDX_W-1:0]      r_idx;
  logic [6:0]            r_seg;
  logic [NUM_DIGITS-1:0] r_dig;
  logic [IDX_W-1:0]      r_didx;
  logic                  r_err;

  logic [NUM_DIGITS-1:0] w_nz;
  logic [NUM_DIGITS-1:0] w_live;
  logic [NUM_DIGITS-1:0] w_onehot;
  logic [3:0]            w_cur;
  logic                  w_acc;
  logic                  w_sup;
  logic                  w_bad;
  logic [6:0]            w_seg;

  function automatic logic [6:0] f_decode(
    input logic [3:0] d
  );
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1111110;
      4'd1:    s = 7'b0110000;
      4'd2:    s = 7'b1101101;
      4'd3:    s = 7'b1111001;
      4'd4:    s = 7'b0110011;
      4'd5:    s = 7'b1011011;
      4'd6:    s = 7'b1011111;
      4'd7:    s = 7'b1110000;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1111011;
      default: s = 7'b0000001;
    endcase
    return s;
  endfunction

  // Pick the scanned digit, find which digits are
  // leading zeros, and flag any non-BCD code.
  always_comb begin
    w_nz     = '0;
    w_live   = '0;
    w_onehot = '0;
    w_cur    = '0;
    w_acc    = 1'b0;
    w_sup    = 1'b0;
    w_bad    = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      w_nz[k] = |r_shadow[4*k +: 4];
      if (r_shadow[4*k +: 4] > 4'd9)
        w_bad = 1'b1;
    end
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      w_acc     = w_acc | w_nz[k];
      w_live[k] = w_acc;
    end
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_cur       = r_shadow[4*k +: 4];
        w_onehot[k] = 1'b1;
        w_sup       = (LZ_SUPPRESS != 0) &&
                      (k != 0) && !w_live[k];
      end
    end
    w_seg = w_sup ? 7'b0 : f_decode(w_cur);
  end

  // Scan timebase: prescaler and digit index.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ps  <= '0;
      r_idx <= '0;
    end else if (r_ps == PS_LAST) begin
      r_ps  <= '0;
      r_idx <= (r_idx == IDX_LAST) ? '0
                                   : r_idx + 1'b1;
    end else begin
      r_ps <= r_ps + 1'b1;
    end
  end

  // Shadow copy of the displayed BCD word.
  always_ff @(posedge clk) begin
    if (rst)
      r_shadow <= '0;
    else if (bus.load)
      r_shadow <= bus.bcd_in;
  end

  // Registered pins, polarity applied last.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg  <= POL7;
      r_dig  <= POLD;
      r_didx <= '0;
      r_err  <= 1'b0;
    end else begin
      r_seg  <= (bus.blank ? 7'b0 : w_seg) ^ POL7;
      r_dig  <= (bus.blank ? '0 : w_onehot) ^ POLD;
      r_didx <= r_idx;
      r_err  <= w_bad;
    end
  end

  assign bus.seg       = r_seg;
  assign bus.dig_en    = r_dig;
  assign bus.digit_idx = r_didx;
  assign bus.error     = r_err;
endmodule

// File: tb/tb_bcd_7seg_scan_driver.sv
// Scoreboard bench: two driver configurations share
// stimulus and are checked against a timing model.
module tb_bcd_7seg_scan_driver;
  typedef struct packed {
    logic [6:0] seg;
    logic [3:0] dig;
    logic [1:0] idx;
    logic       err;
  } out_t;

  typedef struct packed {
    out_t a;
    out_t b;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] bcd = '0;
  logic        blank = 1'b0;

  exp_t        q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          kcnt = 0;
  logic [15:0] sh = '0;

  logic [6:0] glyph [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b0000001, 7'b0000001,
    7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001
  };

  always #5 clk = ~clk;

  bcd_7seg_scan_driver_if #(.NUM_DIGITS(4)) ifa ();
  bcd_7seg_scan_driver_if #(.NUM_DIGITS(4)) ifb ();

  assign ifa.load   = load;
  assign ifa.bcd_in = bcd;
  assign ifa.blank  = blank;
  assign ifb.load   = load;
  assign ifb.bcd_in = bcd;
  assign ifb.blank  = blank;

  bcd_7seg_scan_driver #(
    .NUM_DIGITS(4), .SCAN_DIV(4),
    .ACTIVE_LOW(0), .LZ_SUPPRESS(1)
  ) dut_a (.clk(clk), .rst(rst), .bus(ifa));

  bcd_7seg_scan_driver #(
    .NUM_DIGITS(4), .SCAN_DIV(1),
    .ACTIVE_LOW(1), .LZ_SUPPRESS(0)
  ) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  // k = clock edges since the last reset edge,
  // counting this one; pins show the state before it.
  function automatic out_t model(
    input int sd, input bit al, input bit lz,
    input bit r, input bit bl, input int k,
    input logic [15:0] s
  );
    out_t o;
    int   i;
    int   d;
    if (r) begin
      o.seg = al ? 7'h7F : 7'h00;
      o.dig = al ? 4'hF : 4'h0;
      o.idx = 2'd0;
      o.err = 1'b0;
      return o;
    end
    i = ((k - 1) / sd) % 4;
    d = int'((s >> (4 * i)) & 16'hF);
    o.seg = glyph[d];
    if (lz && i > 0 && (s >> (4 * i)) == 16'h0)
      o.seg = 7'h00;
    o.dig = 4'(1 << i);
    if (bl) begin
      o.seg = 7'h00;
      o.dig = 4'h0;
    end
    if (al) begin
      o.seg = ~o.seg;
      o.dig = ~o.dig;
    end
    o.idx = 2'(i);
    o.err = 1'b0;
    for (int j = 0; j < 4; j++)
      if (((s >> (4 * j)) & 16'hF) > 16'd9)
        o.err = 1'b1;
    return o;
  endfunction

  task automatic step(
    input bit r, input bit ld,
    input logic [15:0] d, input bit bl
  );
    exp_t e;
    @(negedge clk);
    rst   = r;
    load  = ld;
    bcd   = d;
    blank = bl;
    if (r) kcnt = 0;
    else   kcnt++;
    e.a = model(4, 1'b0, 1'b1, r, bl, kcnt, sh);
    e.b = model(1, 1'b1, 1'b0, r, bl, kcnt, sh);
    q.push_back(e);
    if (r)       sh = '0;
    else if (ld) sh = d;
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++)
      step(1'b0, 1'b0, 16'($urandom), 1'b0);
  endtask

  function automatic logic [15:0] rnd_bcd();
    logic [15:0] v;
    v = '0;
    for (int j = 0; j < 4; j++)
      if ($urandom_range(0, 2) != 0)
        v[4*j +: 4] = 4'($urandom_range(0, 15));
    return v;
  endfunction

  task automatic chk(
    input string nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h",
               nm, $time, act, exp);
    end
  endtask

  // Monitor: one expected record per clock edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("a.seg", 32'(ifa.seg), 32'(e.a.seg));
        chk("a.dig_en", 32'(ifa.dig_en), 32'(e.a.dig));
        chk("a.idx", 32'(ifa.digit_idx), 32'(e.a.idx));
        chk("a.error", 32'(ifa.error), 32'(e.a.err));
        chk("b.seg", 32'(ifb.seg), 32'(e.b.seg));
        chk("b.dig_en", 32'(ifb.dig_en), 32'(e.b.dig));
        chk("b.idx", 32'(ifb.digit_idx), 32'(e.b.idx));
        chk("b.error", 32'(ifb.error), 32'(e.b.err));
      end
    end
  end

  // Stimulus: directed scenarios, then random traffic.
  initial begin
    step(1'b1, 1'b0, 16'h0, 1'b0);
    step(1'b1, 1'b0, 16'h0, 1'b0);
    step(1'b0, 1'b1, 16'h1234, 1'b0);
    idle(20);
    idle(6);
    step(1'b1, 1'b0, 16'h0, 1'b0);
    step(1'b0, 1'b1, 16'h1234, 1'b0);
    idle(10);
    step(1'b0, 1'b1, 16'h0007, 1'b0);
    idle(18);
    step(1'b0, 1'b1, 16'h0000, 1'b0);
    idle(18);
    step(1'b0, 1'b1, 16'h12A4, 1'b0);
    idle(18);
    step(1'b0, 1'b1, 16'h0456, 1'b0);
    idle(3);
    for (int c = 0; c < 6; c++)
      step(1'b0, 1'b0, 16'h0, 1'b1);
    idle(12);
    step(1'b0, 1'b1, 16'h8888, 1'b0);
    idle(8);
    for (int c = 0; c < 5; c++)
      step(1'b0, 1'b1, rnd_bcd(), 1'b0);
    for (int c = 0; c < 800; c++)
      step($urandom_range(0, 99) == 0,
           $urandom_range(0, 7) == 0,
           rnd_bcd(),
           $urandom_range(0, 9) == 0);
    repeat (3) @(posedge clk);
    #2;
    n_vec++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d records left, want 0",
               q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end
endmodule
